// File: rtl/mem_interface.sv
`default_nettype none
// ============================================================================
// Module      : mem_interface
// Description : Single-port, word-addressed memory with a one-cycle
//               registered read path. Each read result is returned together
//               with the address it belongs to, so a requester (e.g. the
//               BRISC-V fetch unit) can match data to request.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CORE          core ID, only shown in debug report lines
//   DATA_WIDTH    word width in bits
//   INDEX_BITS    with OFFSET_BITS sets depth: 2**(INDEX_BITS+OFFSET_BITS)
//   OFFSET_BITS   see INDEX_BITS
//   ADDRESS_BITS  width of the word-address ports
// Ports
//   clock     in   single clock, rising-edge active
//   reset     in   asynchronous, active-low reset
//   read      in   read request, sampled on the clock edge
//   write     in   write request, sampled on the clock edge
//   address   in   word address (upper bits beyond the index are ignored)
//   in_data   in   write data
//   out_addr  out  address of the word currently on out_data
//   out_data  out  read data
//   valid     out  out_data/out_addr hold a fresh read result
//   ready     out  interface accepts a request this cycle
//   report    in   debug print strobe
// Configuration
//   MEM_REPORT_EN  when defined, every rising edge with report==1 prints the
//                  interface state plus a free-running 32-bit cycle count.
//                  When undefined, report is ignored and no debug logic exists.
// ============================================================================
module mem_interface #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_BITS   = 6,
  parameter int OFFSET_BITS  = 3,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [ADDRESS_BITS-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    valid,
  output logic                    ready,
  input  logic                    report
);

  localparam int IDX_BITS = INDEX_BITS + OFFSET_BITS;
  localparam int DEPTH    = 2 ** IDX_BITS;

  // Zero-initialised at time 0; reset deliberately leaves contents intact.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Upper address bits are dropped, so addresses alias modulo DEPTH.
  logic [IDX_BITS-1:0] idx;
  assign idx = address[IDX_BITS-1:0];

  // A request is only honoured once the interface has left reset.
  logic do_read;
  logic do_write;
  assign do_read  = ready & read;
  assign do_write = ready & write;

  // Storage write port. Kept separate from the reset domain so that an
  // asserted reset never disturbs the array.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[idx] <= in_data;
    end
  end

  // Registered read path. The array is sampled before the write above takes
  // effect, which gives read-before-write behaviour on a same-edge collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
      out_addr <= '0;
      valid    <= 1'b0;
      ready    <= 1'b0;
    end else begin
      ready <= 1'b1;
      if (do_read) begin
        out_data <= mem[idx];
        out_addr <= address;
        valid    <= 1'b1;
      end else begin
        valid    <= 1'b0;
      end
    end
  end

`ifdef MEM_REPORT_EN
  logic [31:0] cycle;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle <= '0;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (report) begin
      $display("mem_interface core %0d cycle %0d: read=%b write=%b address=%h in_data=%h out_addr=%h out_data=%h valid=%b ready=%b",
               CORE, cycle, read, write, address, in_data, out_addr, out_data, valid, ready);
    end
  end
`endif

  // Ties off inputs/parameters that are intentionally not consumed in every
  // build (upper address bits, report strobe and core ID without reporting).
  logic unused_sink;
  assign unused_sink = ^{report, address, 1'(CORE)};

endmodule
`default_nettype wire

// File: tb/tb_mem_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_interface
// Description : Directed, table-driven self-checking bench for mem_interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_interface;

  localparam int DW = 32;
  localparam int AW = 20;

  logic          clock;
  logic          reset;
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] in_data;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          valid;
  logic          ready;
  logic          report;

  int checks;
  int failures;

  mem_interface #(
    .CORE(0), .DATA_WIDTH(DW), .INDEX_BITS(6), .OFFSET_BITS(3), .ADDRESS_BITS(AW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .address  (address),
    .in_data  (in_data),
    .out_addr (out_addr),
    .out_data (out_data),
    .valid    (valid),
    .ready    (ready),
    .report   (report)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string         name;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic ev, input logic [DW-1:0] ed,
                           input logic [AW-1:0] ea, input logic er);
    check({name, ".valid"},    64'(valid),    64'(ev));
    check({name, ".out_data"}, 64'(out_data), 64'(ed));
    check({name, ".out_addr"}, 64'(out_addr), 64'(ea));
    check({name, ".ready"},    64'(ready),    64'(er));
  endtask

  // Drive a request at the falling edge, check just after the next rising edge.
  task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    read = rd; write = wr; address = a; in_data = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; in_data = '0; report = 1'b0;

    //                name        rd    wr    addr       din            v     data           addr
    vecs[0]  = '{"wr5",        1'b0, 1'b1, 20'd5,     32'hDEADBEEF, 1'b0, 32'h0,        20'd0};
    vecs[1]  = '{"rd5",        1'b1, 1'b0, 20'd5,     32'h0,        1'b1, 32'hDEADBEEF, 20'd5};
    vecs[2]  = '{"wr0",        1'b0, 1'b1, 20'd0,     32'h11,       1'b0, 32'hDEADBEEF, 20'd5};
    vecs[3]  = '{"wr1",        1'b0, 1'b1, 20'd1,     32'h22,       1'b0, 32'hDEADBEEF, 20'd5};
    vecs[4]  = '{"wr2",        1'b0, 1'b1, 20'd2,     32'h33,       1'b0, 32'hDEADBEEF, 20'd5};
    vecs[5]  = '{"rd0",        1'b1, 1'b0, 20'd0,     32'h0,        1'b1, 32'h11,       20'd0};
    vecs[6]  = '{"rd1",        1'b1, 1'b0, 20'd1,     32'h0,        1'b1, 32'h22,       20'd1};
    vecs[7]  = '{"rd2",        1'b1, 1'b0, 20'd2,     32'h0,        1'b1, 32'h33,       20'd2};
    vecs[8]  = '{"idle",       1'b0, 1'b0, 20'd0,     32'h0,        1'b0, 32'h33,       20'd2};
    vecs[9]  = '{"wr7",        1'b0, 1'b1, 20'd7,     32'hAAAA0000, 1'b0, 32'h33,       20'd2};
    vecs[10] = '{"rdwr7",      1'b1, 1'b1, 20'd7,     32'h12345678, 1'b1, 32'hAAAA0000, 20'd7};
    vecs[11] = '{"rd7_new",    1'b1, 1'b0, 20'd7,     32'h0,        1'b1, 32'h12345678, 20'd7};
    vecs[12] = '{"wr515",      1'b0, 1'b1, 20'd515,   32'hCAFE,     1'b0, 32'h12345678, 20'd7};
    vecs[13] = '{"rd3_alias",  1'b1, 1'b0, 20'd3,     32'h0,        1'b1, 32'hCAFE,       20'd3};

    // Reset held for three cycles: everything cleared, not ready.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_out($sformatf("reset_cyc%0d", i), 1'b0, '0, '0, 1'b0);
    end

    // Release; ready rises on the first edge after release.
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_out("ready_rise", 1'b0, '0, '0, 1'b1);

    foreach (vecs[i]) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
      check_out(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_addr, 1'b1);
    end

    // Reset asserted mid-stream of reads: asynchronous clear before any edge.
    step(1'b1, 1'b0, 20'd0, 32'h0);
    check_out("stream_rd0", 1'b1, 32'h11, 20'd0, 1'b1);
    @(negedge clock);
    address = 20'd1;
    #2;
    reset = 1'b0;
    #1;
    check_out("async_clr", 1'b0, '0, '0, 1'b0);
    @(posedge clock);
    #1;
    check_out("reset_hold", 1'b0, '0, '0, 1'b0);

    // Requests presented at the release edge are ignored (ready still 0).
    @(negedge clock);
    reset = 1'b1; read = 1'b1; write = 1'b1; address = 20'd9; in_data = 32'h99;
    @(posedge clock);
    #1;
    check_out("ignored_req", 1'b0, '0, '0, 1'b1);

    step(1'b1, 1'b0, 20'd9, 32'h0);
    check_out("rd9_unwritten", 1'b1, 32'h0, 20'd9, 1'b1);
    step(1'b1, 1'b0, 20'd5, 32'h0);
    check_out("rd5_kept", 1'b1, 32'hDEADBEEF, 20'd5, 1'b1);
    step(1'b1, 1'b0, 20'd2, 32'h0);
    check_out("rd2_kept", 1'b1, 32'h33, 20'd2, 1'b1);
    step(1'b0, 1'b0, 20'd0, 32'h0);
    check_out("final_idle", 1'b0, 32'h33, 20'd2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
